// File: rtl/tile_line_renderer.sv
// Tile-map line renderer: fills a back line buffer from a 20x15 tile map and a sprite ROM
// while the front buffer feeds the VGA stage. Optional TILE_GRID_OVERLAY_EN draws the tile grid.
module tile_line_renderer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  i_next_x,
  input  logic [9:0]  i_next_y,
  output logic [7:0]  o_color_out_c,
  input  logic        i_map_wr_en,
  input  logic [4:0]  i_map_wr_col,
  input  logic [3:0]  i_map_wr_row,
  input  logic [3:0]  i_map_wr_tile,
  output logic [13:0] o_sprite_addr,
  input  logic [7:0]  i_sprite_data,
  output logic        o_render_busy,
  output logic        o_render_overrun
);

  localparam int unsigned X_W       = 10;
  localparam int unsigned Y_W       = 10;
  localparam int unsigned LINE_W    = 9;
  localparam int unsigned PIX_W     = 8;
  localparam int unsigned TILE_W    = 4;
  localparam int unsigned COL_W     = 5;
  localparam int unsigned SUB_W     = 5;
  localparam int unsigned LINE_PIX  = 640;
  localparam int unsigned LAST_LINE = 479;
  localparam int unsigned MAP_COLS  = 20;
  localparam int unsigned MAP_ROWS  = 15;
  localparam int unsigned MAP_DEPTH = MAP_COLS * MAP_ROWS;
  localparam int unsigned MAP_IDX_W = 9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAP,
    S_PIX,
    S_DONE
  } state_t;

  state_t                r_state, nxt_state;
  logic [COL_W-1:0]      r_col, nxt_col;
  logic [SUB_W-1:0]      r_px, nxt_px;
  logic [TILE_W-1:0]     r_tile, nxt_tile;
  logic [13:0]           r_sprite_addr, nxt_sprite_addr;
  logic                  r_pend_en, nxt_pend_en;
  logic [X_W-1:0]        r_pend_x, nxt_pend_x;
  logic                  r_pend_bank, nxt_pend_bank;
  logic                  r_sel, nxt_sel;
  logic                  r_front_valid, nxt_front_valid;
  logic                  r_back_done, nxt_back_done;
  logic [LINE_W-1:0]     r_line, nxt_line;
  logic [Y_W-1:0]        r_next_y;
  logic                  r_busy, nxt_busy;
  logic                  r_overrun, nxt_overrun;

  logic [TILE_W-1:0]     r_map [0:MAP_DEPTH-1];
  logic [PIX_W-1:0]      r_buf0 [0:LINE_PIX-1];
  logic [PIX_W-1:0]      r_buf1 [0:LINE_PIX-1];

  logic                  w_line_evt;
  logic [LINE_W-1:0]     w_next_line;
  logic [MAP_IDX_W-1:0]  w_map_rd_idx;
  logic [MAP_IDX_W-1:0]  w_map_wr_idx;
  logic                  w_map_wr_ok;
  logic [TILE_W-1:0]     w_map_rd;
  logic [PIX_W-1:0]      w_wr_pix;

  assign w_line_evt   = (i_next_y != r_next_y);
  assign w_next_line  = (i_next_y == Y_W'(LAST_LINE)) ? '0 : LINE_W'(i_next_y + Y_W'(1));
  assign w_map_rd_idx = MAP_IDX_W'(r_line[8:5]) * MAP_IDX_W'(MAP_COLS) + MAP_IDX_W'(r_col);
  assign w_map_wr_idx = MAP_IDX_W'(i_map_wr_row) * MAP_IDX_W'(MAP_COLS) + MAP_IDX_W'(i_map_wr_col);
  assign w_map_wr_ok  = i_map_wr_en && (i_map_wr_col < COL_W'(MAP_COLS))
                        && (i_map_wr_row < TILE_W'(MAP_ROWS));
  assign w_map_rd     = r_map[w_map_rd_idx];

`ifdef TILE_GRID_OVERLAY_EN
  assign w_wr_pix = ((r_pend_x[4:0] == '0) || (r_line[4:0] == '0)) ? PIX_W'(8'h49) : i_sprite_data;
`else
  assign w_wr_pix = i_sprite_data;
`endif

  assign o_color_out_c    = r_front_valid ? (r_sel ? r_buf1[i_next_x] : r_buf0[i_next_x]) : '0;
  assign o_sprite_addr    = r_sprite_addr;
  assign o_render_busy    = r_busy;
  assign o_render_overrun = r_overrun;

  // Tile map: registered array, so a same-cycle render read sees the pre-write value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAP_DEPTH; i++) r_map[i] <= '0;
    end else if (w_map_wr_ok) begin
      r_map[w_map_wr_idx] <= i_map_wr_tile;
    end
  end

  // Line buffers carry no reset; writes are gated by the reset pending-write flag.
  always_ff @(posedge clk) begin
    if (r_pend_en) begin
      if (r_pend_bank) r_buf1[r_pend_x] <= w_wr_pix;
      else             r_buf0[r_pend_x] <= w_wr_pix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_col         <= '0;
      r_px          <= '0;
      r_tile        <= '0;
      r_sprite_addr <= '0;
      r_pend_en     <= 1'b0;
      r_pend_x      <= '0;
      r_pend_bank   <= 1'b0;
      r_sel         <= 1'b0;
      r_front_valid <= 1'b0;
      r_back_done   <= 1'b0;
      r_line        <= '0;
      r_next_y      <= '0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_state       <= nxt_state;
      r_col         <= nxt_col;
      r_px          <= nxt_px;
      r_tile        <= nxt_tile;
      r_sprite_addr <= nxt_sprite_addr;
      r_pend_en     <= nxt_pend_en;
      r_pend_x      <= nxt_pend_x;
      r_pend_bank   <= nxt_pend_bank;
      r_sel         <= nxt_sel;
      r_front_valid <= nxt_front_valid;
      r_back_done   <= nxt_back_done;
      r_line        <= nxt_line;
      r_next_y      <= i_next_y;
      r_busy        <= nxt_busy;
      r_overrun     <= nxt_overrun;
    end
  end

  // Render sequencer; a line event overrides everything and restarts at column 0.
  always_comb begin
    nxt_state       = r_state;
    nxt_col         = r_col;
    nxt_px          = r_px;
    nxt_tile        = r_tile;
    nxt_sprite_addr = '0;
    nxt_pend_en     = 1'b0;
    nxt_pend_x      = r_pend_x;
    nxt_pend_bank   = r_pend_bank;
    nxt_sel         = r_sel;
    nxt_front_valid = r_front_valid;
    nxt_back_done   = r_back_done;
    nxt_line        = r_line;
    nxt_overrun     = 1'b0;

    case (r_state)
      S_IDLE: begin
      end
      S_MAP: begin
        nxt_state       = S_PIX;
        nxt_px          = '0;
        nxt_tile        = w_map_rd;
        nxt_sprite_addr = {w_map_rd, r_line[4:0], SUB_W'(0)};
      end
      S_PIX: begin
        nxt_pend_en   = 1'b1;
        nxt_pend_x    = {r_col, r_px};
        nxt_pend_bank = ~r_sel;
        if (r_px == SUB_W'(31)) begin
          if (r_col == COL_W'(MAP_COLS - 1)) begin
            nxt_state = S_DONE;
          end else begin
            nxt_state = S_MAP;
            nxt_col   = r_col + COL_W'(1);
          end
        end else begin
          nxt_px          = r_px + SUB_W'(1);
          nxt_sprite_addr = {r_tile, r_line[4:0], r_px + SUB_W'(1)};
        end
      end
      S_DONE: begin
        nxt_state     = S_IDLE;
        nxt_back_done = 1'b1;
      end
      default: begin
        nxt_state = S_IDLE;
      end
    endcase

    if (w_line_evt) begin
      nxt_overrun     = (r_state != S_IDLE);
      nxt_state       = S_MAP;
      nxt_col         = '0;
      nxt_px          = '0;
      nxt_sprite_addr = '0;
      nxt_pend_en     = 1'b0;
      nxt_sel         = ~r_sel;
      nxt_front_valid = r_back_done;
      nxt_back_done   = 1'b0;
      nxt_line        = w_next_line;
    end

    nxt_busy = (nxt_state != S_IDLE);
  end

endmodule

// File: tb/tb_tile_line_renderer.sv
// Self-checking bench for tile_line_renderer: random ROM contents and tile map, checked
// against a per-pixel model; honours TILE_GRID_OVERLAY_EN when defined.
module tb_tile_line_renderer;

  logic        clk;
  logic        rst_n;
  logic [9:0]  i_next_x;
  logic [9:0]  i_next_y;
  logic [7:0]  o_color_out_c;
  logic        i_map_wr_en;
  logic [4:0]  i_map_wr_col;
  logic [3:0]  i_map_wr_row;
  logic [3:0]  i_map_wr_tile;
  logic [13:0] o_sprite_addr;
  logic [7:0]  i_sprite_data;
  logic        o_render_busy;
  logic        o_render_overrun;

  int          n_checks;
  int          n_fail;
  logic [7:0]  rom_key;
  logic [3:0]  mm [0:14][0:19];
  int          cur_y;

  tile_line_renderer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_next_x         (i_next_x),
    .i_next_y         (i_next_y),
    .o_color_out_c    (o_color_out_c),
    .i_map_wr_en      (i_map_wr_en),
    .i_map_wr_col     (i_map_wr_col),
    .i_map_wr_row     (i_map_wr_row),
    .i_map_wr_tile    (i_map_wr_tile),
    .o_sprite_addr    (o_sprite_addr),
    .i_sprite_data    (i_sprite_data),
    .o_render_busy    (o_render_busy),
    .o_render_overrun (o_render_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_f(input logic [13:0] a);
    logic [31:0] h;
    h = {18'd0, a} * 32'd40503 + {24'd0, rom_key};
    return h[15:8] ^ h[7:0];
  endfunction

  // Synchronous sprite ROM: data follows the address by one clock.
  always @(posedge clk) i_sprite_data <= rom_f(o_sprite_addr);

  function automatic logic [7:0] exp_pix(input int line, input int x);
    int tile;
    logic [13:0] a;
    logic [7:0] p;
    tile = int'(mm[line / 32][x / 32]);
    a = 14'(tile * 1024 + (line % 32) * 32 + (x % 32));
    p = rom_f(a);
`ifdef TILE_GRID_OVERLAY_EN
    if ((x % 32) == 0 || (line % 32) == 0) p = 8'h49;
`endif
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic map_write(input int col, input int row, input int tile);
    @(negedge clk);
    i_map_wr_en   = 1'b1;
    i_map_wr_col  = 5'(col);
    i_map_wr_row  = 4'(row);
    i_map_wr_tile = 4'(tile);
    @(negedge clk);
    i_map_wr_en = 1'b0;
    if (col < 20 && row < 15) mm[row][col] = 4'(tile);
  endtask

  task automatic set_y(input int v);
    @(negedge clk);
    i_next_y = 10'(v);
    cur_y = v;
  endtask

  task automatic wait_idle(output int busy_n, output int ovr_n);
    int k;
    busy_n = 0;
    ovr_n  = 0;
    k      = 0;
    while (o_render_busy === 1'b1 && k < 2000) begin
      busy_n++;
      if (o_render_overrun === 1'b1) ovr_n++;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic start_line(input int v);
    int bn, on;
    set_y(v);
    @(negedge clk);
    wait_idle(bn, on);
    chk($sformatf("busy_len_y%0d", v), 32'(bn), 32'd661);
    chk($sformatf("no_overrun_y%0d", v), 32'(on), 32'd0);
  endtask

  task automatic check_line(input int line);
    for (int x = 0; x < 640; x++) begin
      i_next_x = 10'(x);
      #1;
      chk($sformatf("pix_l%0d_x%0d", line, x), 32'(o_color_out_c), 32'(exp_pix(line, x)));
    end
  endtask

  task automatic check_black(input int line);
    for (int x = 0; x < 640; x++) begin
      i_next_x = 10'(x);
      #1;
      chk($sformatf("black_l%0d_x%0d", line, x), 32'(o_color_out_c), 32'd0);
    end
  endtask

  initial begin
    int a, v, bn, on;
    n_checks = 0;
    n_fail   = 0;
    cur_y    = 0;
    rom_key  = 8'($urandom);
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 20; c++) mm[r][c] = 4'd0;
    rst_n         = 1'b0;
    i_next_x      = '0;
    i_next_y      = '0;
    i_map_wr_en   = 1'b0;
    i_map_wr_col  = '0;
    i_map_wr_row  = '0;
    i_map_wr_tile = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(o_render_busy), 32'd0);
    chk("rst_addr", 32'(o_sprite_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy_rel", 32'(o_render_busy), 32'd0);
    chk("rst_overrun", 32'(o_render_overrun), 32'd0);
    chk("rst_addr_rel", 32'(o_sprite_addr), 32'd0);
    chk("rst_color", 32'(o_color_out_c), 32'd0);

    // Out-of-range map writes must be dropped.
    map_write(20, 0, 7);
    map_write(0, 15, 9);
    map_write(31, 14, 3);

    start_line(479);
    start_line(0);
    check_line(0);
    start_line(1);
    check_line(1);

    for (int i = 0; i < 12; i++)
      map_write($urandom_range(0, 21), $urandom_range(0, 15), $urandom_range(0, 15));
    map_write(3, 0, 5);
    map_write(2, 0, 0);

    start_line(479);
    start_line(0);
    check_line(0);
    i_next_x = 10'd96;
    #1;
    chk("tile5_x96", 32'(o_color_out_c), 32'(exp_pix(0, 96)));
    i_next_x = 10'd95;
    #1;
    chk("tile0_x95", 32'(o_color_out_c), 32'(exp_pix(0, 95)));

    start_line(31);
    start_line(32);
    check_line(32);
    start_line(33);
    check_line(33);

    for (int r = 0; r < 3; r++) begin
      v = $urandom_range(40, 470);
      if (v == cur_y) v = v + 2;
      start_line(v);
      start_line(v + 1);
      check_line(v + 1);
    end

    // Abort a render 300 cycles in with a new line event.
    a = (cur_y + 5 <= 470) ? cur_y + 5 : 100;
    start_line(a);
    set_y(a + 1);
    repeat (300) @(negedge clk);
    chk("busy_before_abort", 32'(o_render_busy), 32'd1);
    set_y(a + 2);
    @(negedge clk);
    chk("overrun_pulse", 32'(o_render_overrun), 32'd1);
    chk("busy_after_abort", 32'(o_render_busy), 32'd1);
    @(negedge clk);
    chk("overrun_single", 32'(o_render_overrun), 32'd0);
    check_black(a + 2);
    wait_idle(bn, on);
    chk("restart_no_2nd_overrun", 32'(on), 32'd0);
    chk("restart_completes", 32'(o_render_busy), 32'd0);
    start_line(a + 3);
    check_line(a + 3);

    // Asynchronous reset in the middle of a render.
    set_y(cur_y + 1);
    repeat (200) @(negedge clk);
    i_next_x = 10'd100;
    #2;
    chk("pre_rst_busy", 32'(o_render_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(o_render_busy), 32'd0);
    chk("async_rst_color", 32'(o_color_out_c), 32'd0);
    chk("async_rst_addr", 32'(o_sprite_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_line_renderer.md
TILE_LINE_RENDERER -- requirements
Module: tile_line_renderer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports as listed below, clock and reset first.
REQ-002 clock  input  1  pixel clock, 25 MHz, shared with the VGA timing stage.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 next_x  input  10  x of the next pixel from the VGA timing stage, 0..639.
REQ-005 next_y  input  10  y of the next pixel from the VGA timing stage, 0..479; held at 0 outside active lines.
REQ-006 color_out  output  8  RRRGGGBB pixel for next_x, driven to the VGA timing stage's color_in.
REQ-007 map_wr_en  input  1  tile-map write strobe, one write per cycle, always accepted.
REQ-008 map_wr_col  input  5  tile column, 0..19.
REQ-009 map_wr_row  input  4  tile row, 0..14.
REQ-010 map_wr_tile  input  4  tile id.
REQ-011 sprite_addr  output  14  sprite ROM address {tile_id[3:0], py[4:0], px[4:0]}.
REQ-012 sprite_data  input  8  sprite ROM data, valid exactly 1 cycle after sprite_addr.
REQ-013 render_busy  output  1  high while a line render is in progress.
REQ-014 render_overrun  output  1  one-cycle pulse when a render is aborted by a new line.

Function
REQ-015 The tile map SHALL hold 20x15 entries of 4 bits, 32x32-pixel tiles; writes with col>19 or row>14 SHALL be ignored.
REQ-016 Two 640x8 line buffers SHALL be kept: front (displayed) and back (being rendered).
REQ-017 color_out SHALL be front[next_x], combinational, zero latency; 8'h00 while front_valid=0.
REQ-018 A line event SHALL be detected when registered next_y differs from current next_y (one-cycle pulse, includes 479->0).
REQ-019 On a line event with value v: swap front/back, set front_valid to back_done, start rendering line (v+1) mod 480 into the new back buffer.
REQ-020 FSM states: IDLE, MAP (read tile id for column c, 1 cycle), PIX (32 cycles, issue sprite_addr for px 0..31), DONE.
REQ-021 Transitions: IDLE->MAP on line event; MAP->PIX; PIX->MAP after px=31 if c<19, else PIX->DONE; DONE->IDLE after last returned pixel written, setting back_done=1.
REQ-022 Returned sprite_data SHALL be written to back[32*c+px] one cycle after issue; a full line SHALL take 661 cycles (<800-cycle line period).
REQ-023 render_busy SHALL be high in MAP, PIX, DONE.
REQ-024 Line event while busy: abort, pulse render_overrun, back_done=0 (swapped buffer shows black), restart for new line.
REQ-025 Tile-map write and render read of the same entry in one cycle: read returns the old value; write takes effect next cycle.
REQ-026 sprite_addr SHALL be 0 outside PIX.

Reset
REQ-027 Reset SHALL clear FSM to IDLE, c, px, registered next_y, front_valid, back_done, render_busy, render_overrun, sprite_addr to 0, buffer select to 0; color_out therefore 8'h00.
REQ-028 Tile map SHALL reset to all 0; line buffer contents are not reset.
REQ-029 Reset asserted mid-render SHALL abandon the render with no further buffer writes.

Configuration
REQ-030 Macro TILE_GRID_OVERLAY_EN: when defined, rendered pixels with x[4:0]==0 or y[4:0]==0 SHALL be written as 8'h49 instead of sprite_data; when undefined, sprite_data is written unmodified and no overlay logic exists.

Verification
REQ-031 Reset, then next_y 479->0: render_busy high 661 cycles, no overrun; next_y 0->1 -> color_out for every next_x equals ROM pixel of tile 0 row 1.
REQ-032 Write col=3,row=0,tile=5, render line 0, swap -> next_x=96..127 show ROM tile 5 row 0; next_x=95 shows tile 0.
REQ-033 Write col=20,row=0,tile=7 -> map unchanged; next_x=0..639 of line 0 show tile 0.
REQ-034 Line event 300 cycles into render -> render_overrun single pulse, color_out=8'h00 for whole following line.
REQ-035 With TILE_GRID_OVERLAY_EN, line y=32 -> all 640 pixels 8'h49; line y=33 -> next_x=0,32,...,608 are 8'h49, others ROM data.
REQ-036 Reset asserted at cycle 200 of a render -> render_busy=0 and color_out=8'h00 immediately, asynchronously.
